ervp_lz_normalizer: RTL and testbench

ERVP_LZ_NORMALIZER -- requirements
Module: ervp_lz_normalizer

---
 rtl/ervp_lz_normalizer.sv | 102 ++++++++++
 tb/tb_ervp_lz_normalizer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ervp_lz_normalizer.sv
// ervp_lz_normalizer
// Two-stage leading-zero / redundant-sign-bit normalizer with valid/ready
// handshaking. S1 captures the input word. S2 captures the saturated shift
// count, the left-shifted word and a flag for words with no significant bit.
module ervp_lz_normalizer #(
    parameter int BW_DATA         = 32,
    parameter int BW_SHIFT_AMOUNT = 6,
    parameter int SIGNED_DATA     = 0
) (
    input  logic                       clk,
    input  logic                       rstnn,
    input  logic                       i_clear,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [BW_DATA-1:0]         i_data,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [BW_DATA-1:0]         o_data,
    output logic [BW_SHIFT_AMOUNT-1:0] o_shift_amount,
    output logic                       o_zero
);

    // The largest positive value the signed shift-amount port can carry
    localparam int MAXC_SA = (2 ** (BW_SHIFT_AMOUNT - 1)) - 1;
    localparam int MAXC    = ((BW_DATA - 1) < MAXC_SA) ? (BW_DATA - 1) : MAXC_SA;
    localparam int BW_CNT  = $clog2(BW_DATA + 1);

    logic                       r_s1_valid;
    logic [BW_DATA-1:0]         r_s1_data;
    logic                       r_s2_valid;
    logic [BW_DATA-1:0]         r_o_data;
    logic [BW_SHIFT_AMOUNT-1:0] r_o_shift;
    logic                       r_o_zero;

    logic                       w_s2_advance;
    logic [BW_DATA-1:0]         w_scan;
    logic                       w_zero;
    logic [BW_CNT-1:0]          w_count;
    logic [BW_CNT-1:0]          w_count_sat;

    assign w_s2_advance   = !r_s2_valid || o_ready;
    assign i_ready        = !r_s1_valid || w_s2_advance;
    assign o_valid        = r_s2_valid;
    assign o_data         = r_o_data;
    assign o_shift_amount = r_o_shift;
    assign o_zero         = r_o_zero;

    // Build the word to scan: for signed data, bit k is set where the bit
    // differs from the sign, and a sentinel 1 at the LSB caps the count at
    // BW_DATA-1 so the sign bit itself is never counted as redundant.
    always_comb begin
        w_scan = r_s1_data;
        w_zero = (r_s1_data == '0);
        if (SIGNED_DATA != 0) begin
            w_scan = {r_s1_data[BW_DATA-2:0] ^ {(BW_DATA-1){r_s1_data[BW_DATA-1]}}, 1'b1};
            w_zero = (w_scan[BW_DATA-1:1] == '0);
        end
    end

    // Leading-zero count of the scan word; the highest set bit wins
    always_comb begin
        w_count = BW_CNT'(BW_DATA);
        for (int unsigned k = 0; k < BW_DATA; k++) begin
            if (w_scan[k]) begin
                w_count = BW_CNT'(BW_DATA - 1 - k);
            end
        end
        w_count_sat = (w_count > BW_CNT'(MAXC)) ? BW_CNT'(MAXC) : w_count;
    end

    // Pipeline state: clear has priority, S2 loads when it can advance, S1
    // refills in the same cycle it hands its word on.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_o_data   <= '0;
            r_o_shift  <= '0;
            r_o_zero   <= 1'b0;
        end else if (i_clear) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_advance) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_o_data  <= r_s1_data << w_count_sat;
                    r_o_shift <= BW_SHIFT_AMOUNT'(w_count_sat);
                    r_o_zero  <= w_zero;
                end
            end
            if (i_ready) begin
                r_s1_valid <= i_valid;
                if (i_valid) begin
                    r_s1_data <= i_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ervp_lz_normalizer.sv
// Bench for ervp_lz_normalizer: one unsigned and one signed instance share
// all inputs. A queue model tracks words in flight and a negedge process
// checks both instances against it every cycle.
module tb_ervp_lz_normalizer;

    localparam int BW   = 32;
    localparam int SA   = 6;
    localparam int MAXC = ((2 ** (SA - 1)) - 1 < BW - 1) ? (2 ** (SA - 1)) - 1 : BW - 1;

    logic          clk     = 1'b0;
    logic          rstnn   = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready = 1'b0;
    logic [BW-1:0] i_data  = '0;

    logic          u_iready, u_ovalid, u_zero;
    logic [BW-1:0] u_data;
    logic [SA-1:0] u_sh;
    logic          s_iready, s_ovalid, s_zero;
    logic [BW-1:0] s_data;
    logic [SA-1:0] s_sh;

    always #5 clk = ~clk;

    ervp_lz_normalizer #(.BW_DATA(BW), .BW_SHIFT_AMOUNT(SA), .SIGNED_DATA(0)) u_dut (
        .clk(clk), .rstnn(rstnn), .i_clear(i_clear), .i_valid(i_valid), .i_ready(u_iready),
        .i_data(i_data), .o_valid(u_ovalid), .o_ready(o_ready), .o_data(u_data),
        .o_shift_amount(u_sh), .o_zero(u_zero));

    ervp_lz_normalizer #(.BW_DATA(BW), .BW_SHIFT_AMOUNT(SA), .SIGNED_DATA(1)) s_dut (
        .clk(clk), .rstnn(rstnn), .i_clear(i_clear), .i_valid(i_valid), .i_ready(s_iready),
        .i_data(i_data), .o_valid(s_ovalid), .o_ready(o_ready), .o_data(s_data),
        .o_shift_amount(s_sh), .o_zero(s_zero));

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [BW-1:0] d;
        int            t;
    } ent_t;
    ent_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Normalize by repeatedly shifting while the top bit is not significant
    function automatic void norm(input logic [BW-1:0] d, input bit sgn,
                                 output logic [BW-1:0] od, output int sh, output bit z);
        logic [BW-1:0] x;
        int n;
        x = d;
        n = 0;
        while (n < MAXC && (sgn ? (x[BW-1] == x[BW-2]) : (x[BW-1] == 1'b0))) begin
            x = x << 1;
            n++;
        end
        od = x;
        sh = n;
        z  = sgn ? (d == '0 || d == '1) : (d == '0);
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].t + 1 < cyc);
    endfunction

    function automatic bit m_ready();
        return (q.size() < 2) || o_ready;
    endfunction

    always @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            q.delete();
        end else begin
            bit acc, dlv;
            acc = i_valid && m_ready();
            dlv = m_valid() && o_ready;
            if (i_clear) begin
                q.delete();
            end else begin
                if (dlv) void'(q.pop_front());
                if (acc) q.push_back('{d: i_data, t: cyc});
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        bit mv, mr, ez;
        logic [BW-1:0] ed;
        int esh;
        mv = m_valid();
        mr = m_ready();
        chk("u_o_valid", 32'(u_ovalid), 32'(mv));
        chk("s_o_valid", 32'(s_ovalid), 32'(mv));
        chk("u_i_ready", 32'(u_iready), 32'(mr));
        chk("s_i_ready", 32'(s_iready), 32'(mr));
        if (mv) begin
            norm(q[0].d, 1'b0, ed, esh, ez);
            chk("u_o_data", u_data, ed);
            chk("u_o_shift", 32'(u_sh), 32'(esh));
            chk("u_o_zero", 32'(u_zero), 32'(ez));
            norm(q[0].d, 1'b1, ed, esh, ez);
            chk("s_o_data", s_data, ed);
            chk("s_o_shift", 32'(s_sh), 32'(esh));
            chk("s_o_zero", 32'(s_zero), 32'(ez));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input logic [31:0] d,
                            input logic [31:0] eud, input int eush, input bit euz,
                            input logic [31:0] esd, input int essh, input bit esz);
        i_valid = 1'b1;
        i_data  = d;
        o_ready = 1'b1;
        step();
        i_valid = 1'b0;
        chk("lat_s1_only", 32'(u_ovalid), 32'd0);
        step();
        chk("lat_valid", 32'(u_ovalid), 32'd1);
        chk("lit_u_data", u_data, eud);
        chk("lit_u_shift", 32'(u_sh), 32'(eush));
        chk("lit_u_zero", 32'(u_zero), 32'(euz));
        chk("lit_s_data", s_data, esd);
        chk("lit_s_shift", 32'(s_sh), 32'(essh));
        chk("lit_s_zero", 32'(s_zero), 32'(esz));
        step();
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_u_valid"}, 32'(u_ovalid), 32'd0);
        chk({nm, "_u_ready"}, 32'(u_iready), 32'd1);
        chk({nm, "_u_data"}, u_data, 32'd0);
        chk({nm, "_u_shift"}, 32'(u_sh), 32'd0);
        chk({nm, "_u_zero"}, 32'(u_zero), 32'd0);
        chk({nm, "_s_valid"}, 32'(s_ovalid), 32'd0);
        chk({nm, "_s_data"}, s_data, 32'd0);
        chk({nm, "_s_zero"}, 32'(s_zero), 32'd0);
    endtask

    initial begin
        logic [BW-1:0] pd, held;
        int psh, acc_cnt;
        bit pz;

        // Pin the model itself against hand-computed values
        norm(32'h0001_2345, 1'b0, pd, psh, pz);
        chk("pin_u_12345_data", pd, 32'h91A2_8000);
        chk("pin_u_12345_shift", 32'(psh), 32'd15);
        norm(32'hFFFF_FFF0, 1'b1, pd, psh, pz);
        chk("pin_s_fff0_data", pd, 32'h8000_0000);
        chk("pin_s_fff0_shift", 32'(psh), 32'd27);

        // Reset state, then first cycle after release
        #12;
        chk_reset_outputs("in_reset");
        @(posedge clk);
        #2 rstnn = 1'b1;
        @(negedge clk);
        chk("post_rel_u_valid", 32'(u_ovalid), 32'd0);
        chk("post_rel_u_ready", 32'(u_iready), 32'd1);
        step();

        // Directed vectors with literal expectations for both flavours
        send_chk(32'h0000_0001, 32'h8000_0000, 31, 1'b0, 32'h4000_0000, 30, 1'b0);
        send_chk(32'h0000_0000, 32'h0000_0000, 31, 1'b1, 32'h0000_0000, 31, 1'b1);
        send_chk(32'h0001_2345, 32'h91A2_8000, 15, 1'b0, 32'h48D1_4000, 14, 1'b0);
        send_chk(32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 1'b0, 32'h8000_0000, 27, 1'b0);
        send_chk(32'h4000_0000, 32'h8000_0000, 1, 1'b0, 32'h4000_0000, 0, 1'b0);
        send_chk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 32'h8000_0000, 31, 1'b1);

        // Back-to-back stream of 8 words
        o_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_data  = 32'h1 << (3 * i + 1);
            chk("stream_ready", 32'(u_iready), 32'd1);
            step();
        end
        i_valid = 1'b0;
        repeat (3) step();

        // Stall: two words enter, then the input side backs up
        o_ready = 1'b0;
        acc_cnt = 0;
        held    = '0;
        for (int j = 0; j < 5; j++) begin
            i_valid = 1'b1;
            i_data  = 32'h0000_00A5 << (4 * j);
            chk("stall_i_ready", 32'(u_iready), (j < 2) ? 32'd1 : 32'd0);
            if (u_iready) acc_cnt++;
            if (j == 3) held = u_data;
            if (j == 4) chk("stall_hold_data", u_data, held);
            step();
        end
        chk("stall_accepts", 32'(acc_cnt), 32'd2);
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (4) step();

        // Flush with both stages full and a word offered
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h0000_0F00;
        step();
        i_data  = 32'h0003_0000;
        step();
        i_clear = 1'b1;
        o_ready = 1'b1;
        i_data  = 32'h0000_0077;
        step();
        i_clear = 1'b0;
        i_valid = 1'b0;
        chk("flush_valid", 32'(u_ovalid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_dropped", 32'(u_ovalid), 32'd0);
        end

        // Mixed traffic with random backpressure and occasional clears
        for (int k = 0; k < 60; k++) begin
            i_valid = 1'($urandom_range(0, 1));
            o_ready = ($urandom_range(0, 3) != 0);
            i_clear = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 4))
                0:       i_data = '0;
                1:       i_data = '1;
                2:       i_data = 32'h1 << $urandom_range(0, 31);
                default: i_data = $urandom >> $urandom_range(0, 31);
            endcase
            step();
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
        o_ready = 1'b1;
        repeat (4) step();

        // Reset mid-stream with both stages full
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h0000_1234;
        step();
        i_data  = 32'h00AB_0000;
        step();
        #2 rstnn = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clk);
        #2 rstnn = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        chk("rel_u_ready", 32'(u_iready), 32'd1);
        chk("rel_u_valid", 32'(u_ovalid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rel_no_ghost", 32'(u_ovalid), 32'd0);
        end

        chk("model_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
